// File: rtl/calc_core_n.sv
// Keypad calculator core: decimal entry of two signed WIDTH-bit operands, add/sub/mul/restoring divide.
// Build option: define CALC_SATURATE_EN to clamp out-of-range results instead of wrapping them.
module calc_core_n #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic [3:0]              keypad_input,
   input  logic                    read_input,
   input  logic [3:0]              operator_input,
   input  logic                    equal_input,
   input  logic                    clear_input,
   output logic signed [WIDTH-1:0] display_output,
   output logic                    complete,
   output logic                    busy,
   output logic                    overflow,
   output logic                    error
);

   localparam int W2  = 2 * WIDTH;
   localparam int CW  = $clog2(MAX_DIGITS + 1);
   localparam int DCW = $clog2(WIDTH);

   localparam logic [CW-1:0]    MAX_CNT  = CW'(MAX_DIGITS);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [DCW-1:0]   DIV_LAST = DCW'(WIDTH - 1);
   localparam logic [DCW-1:0]   DIV_ONE  = DCW'(1);
   localparam logic [WIDTH-1:0] MAX_W    = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [W2-1:0]    ONE_2W   = {{(W2-1){1'b0}}, 1'b1};
`ifdef CALC_SATURATE_EN
   localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      ENTER_B = 3'd1,
      EXEC    = 3'd2,
      DIV_RUN = 3'd3,
      FIXUP   = 3'd4,
      COMMIT  = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [3:0]       op_r;
   logic [CW-1:0]    count_r;
   logic             read_q_r;
   logic             equal_q_r;
   logic             op_q_r;
   logic [W2-1:0]    wide_r;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] rem_r;
   logic [DCW-1:0]   div_cnt_r;
   logic             q_neg_r;

   logic             read_edge_s;
   logic             equal_edge_s;
   logic             op_edge_s;
   logic             op_valid_s;
   logic [WIDTH-1:0] acc_cur_s;
   logic [WIDTH+4:0] acc_ext_s;
   logic [WIDTH+4:0] acc_next_s;
   logic             digit_ok_s;
   logic [W2-1:0]    a_ext_s;
   logic [W2-1:0]    b_ext_s;
   logic [WIDTH:0]   rem_shift_s;
   logic [WIDTH:0]   diff_s;
   logic             q_bit_s;
   logic [WIDTH-1:0] rem_next_s;
   logic [WIDTH:0]   hi_s;
   logic             ovf_s;
   logic [WIDTH-1:0] commit_s;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      if (x[WIDTH-1]) begin
         mag = (~x) + ONE_W;
      end else begin
         mag = x;
      end
   endfunction

   function automatic logic [W2-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
      logic [W2-1:0] ext;
      ext = {{WIDTH{1'b0}}, m};
      if (neg) begin
         apply_sign = (~ext) + ONE_2W;
      end else begin
         apply_sign = ext;
      end
   endfunction

   // Strobe edges, operator legality and the candidate accumulator value for a digit press
   always_comb begin
      read_edge_s  = read_input & ~read_q_r;
      equal_edge_s = equal_input & ~equal_q_r;
      op_edge_s    = (|operator_input) & ~op_q_r;
      case (operator_input)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: op_valid_s = 1'b1;
         default:                            op_valid_s = 1'b0;
      endcase
      acc_cur_s  = (state_r == ENTER_B) ? b_r : a_r;
      acc_ext_s  = {5'b00000, acc_cur_s};
      acc_next_s = (acc_ext_s << 3'd3) + (acc_ext_s << 3'd1) + {{(WIDTH+1){1'b0}}, keypad_input};
      digit_ok_s = (keypad_input <= 4'd9) && (count_r != MAX_CNT) && (acc_next_s <= {5'b00000, MAX_W});
   end

   // Operand sign extension and one restoring-division step on magnitudes
   always_comb begin
      a_ext_s     = {{WIDTH{a_r[WIDTH-1]}}, a_r};
      b_ext_s     = {{WIDTH{b_r[WIDTH-1]}}, b_r};
      rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
      diff_s      = rem_shift_s - {1'b0, dvs_r};
      q_bit_s     = ~diff_s[WIDTH];
      rem_next_s  = q_bit_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
   end

   // Range check of the double-width result: in range only if the top WIDTH+1 bits agree
   always_comb begin
      hi_s  = wide_r[W2-1:WIDTH-1];
      ovf_s = ~((&hi_s) | ~(|hi_s));
`ifdef CALC_SATURATE_EN
      if (ovf_s) begin
         commit_s = wide_r[W2-1] ? MIN_W : MAX_W;
      end else begin
         commit_s = wide_r[WIDTH-1:0];
      end
`else
      commit_s = wide_r[WIDTH-1:0];
`endif
   end

   // Main controller: entry, execution, divide sequencing and registered outputs
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_r        <= ENTER_A;
         a_r            <= '0;
         b_r            <= '0;
         op_r           <= 4'b0000;
         count_r        <= '0;
         read_q_r       <= 1'b0;
         equal_q_r      <= 1'b0;
         op_q_r         <= 1'b0;
         wide_r         <= '0;
         dvd_r          <= '0;
         dvs_r          <= '0;
         rem_r          <= '0;
         div_cnt_r      <= '0;
         q_neg_r        <= 1'b0;
         display_output <= '0;
         complete       <= 1'b0;
         busy           <= 1'b0;
         overflow       <= 1'b0;
         error          <= 1'b0;
      end else begin
         read_q_r  <= read_input;
         equal_q_r <= equal_input;
         op_q_r    <= |operator_input;
         if (clear_input) begin
            state_r        <= ENTER_A;
            a_r            <= '0;
            b_r            <= '0;
            op_r           <= 4'b0000;
            count_r        <= '0;
            wide_r         <= '0;
            dvd_r          <= '0;
            dvs_r          <= '0;
            rem_r          <= '0;
            div_cnt_r      <= '0;
            q_neg_r        <= 1'b0;
            display_output <= '0;
            complete       <= 1'b0;
            busy           <= 1'b0;
            overflow       <= 1'b0;
            error          <= 1'b0;
         end else begin
            case (state_r)
               ENTER_A, ENTER_B: begin
                  if (equal_edge_s) begin
                     if (state_r == ENTER_B) begin
                        state_r <= EXEC;
                        busy    <= 1'b1;
                     end else begin
                        display_output <= a_r;
                        complete       <= 1'b1;
                        state_r        <= DONE;
                     end
                  end else if (op_edge_s) begin
                     if (op_valid_s) begin
                        op_r <= operator_input;
                        if (state_r == ENTER_A) begin
                           b_r            <= '0;
                           count_r        <= '0;
                           display_output <= '0;
                           state_r        <= ENTER_B;
                        end
                     end
                  end else if (read_edge_s && digit_ok_s) begin
                     if (state_r == ENTER_B) begin
                        b_r <= acc_next_s[WIDTH-1:0];
                     end else begin
                        a_r <= acc_next_s[WIDTH-1:0];
                     end
                     count_r        <= count_r + CNT_ONE;
                     display_output <= acc_next_s[WIDTH-1:0];
                  end
               end
               EXEC: begin
                  case (op_r)
                     4'b0001: begin
                        wide_r  <= a_ext_s + b_ext_s;
                        state_r <= COMMIT;
                        busy    <= 1'b0;
                     end
                     4'b0010: begin
                        wide_r  <= a_ext_s - b_ext_s;
                        state_r <= COMMIT;
                        busy    <= 1'b0;
                     end
                     4'b0100: begin
                        wide_r  <= a_ext_s * b_ext_s;
                        state_r <= COMMIT;
                        busy    <= 1'b0;
                     end
                     4'b1000: begin
                        if (b_r == '0) begin
                           error          <= 1'b1;
                           display_output <= '0;
                           complete       <= 1'b1;
                           busy           <= 1'b0;
                           state_r        <= DONE;
                        end else begin
                           dvd_r     <= mag(a_r);
                           dvs_r     <= mag(b_r);
                           rem_r     <= '0;
                           div_cnt_r <= '0;
                           q_neg_r   <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
                           state_r   <= DIV_RUN;
                        end
                     end
                     default: begin
                        wide_r  <= a_ext_s;
                        state_r <= COMMIT;
                        busy    <= 1'b0;
                     end
                  endcase
               end
               DIV_RUN: begin
                  // dvd_r doubles as the quotient: dividend bits shift out, quotient bits shift in
                  rem_r     <= rem_next_s;
                  dvd_r     <= {dvd_r[WIDTH-2:0], q_bit_s};
                  div_cnt_r <= div_cnt_r + DIV_ONE;
                  if (div_cnt_r == DIV_LAST) begin
                     state_r <= FIXUP;
                     busy    <= 1'b0;
                  end
               end
               FIXUP: begin
                  wide_r  <= apply_sign(q_neg_r, dvd_r);
                  state_r <= COMMIT;
               end
               COMMIT: begin
                  display_output <= commit_s;
                  overflow       <= ovf_s;
                  complete       <= 1'b1;
                  state_r        <= DONE;
               end
               DONE: begin
                  if (equal_edge_s) begin
                     state_r <= DONE;
                  end else if (op_edge_s) begin
                     if (op_valid_s) begin
                        a_r            <= display_output;
                        op_r           <= operator_input;
                        b_r            <= '0;
                        count_r        <= '0;
                        display_output <= '0;
                        complete       <= 1'b0;
                        overflow       <= 1'b0;
                        error          <= 1'b0;
                        state_r        <= ENTER_B;
                     end
                  end else if (read_edge_s && (keypad_input <= 4'd9)) begin
                     a_r            <= {{(WIDTH-4){1'b0}}, keypad_input};
                     b_r            <= '0;
                     count_r        <= CNT_ONE;
                     display_output <= {{(WIDTH-4){1'b0}}, keypad_input};
                     complete       <= 1'b0;
                     overflow       <= 1'b0;
                     error          <= 1'b0;
                     state_r        <= ENTER_A;
                  end
               end
               default: begin
                  state_r <= ENTER_A;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calc_core_n.sv
// Self-checking bench for calc_core_n (WIDTH=16): vector table plus hand sequences, scoreboard on results.
module tb_calc_core_n;

   localparam int WIDTH = 16;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b1000;
`ifdef CALC_SATURATE_EN
   localparam int MUL_OVF = 32767;
   localparam int ADD_OVF = 32767;
   localparam int SQ_OVF  = 32767;
`else
   localparam int MUL_OVF = -5536;
   localparam int ADD_OVF = -32768;
   localparam int SQ_OVF  = 1;
`endif

   logic                    clk = 1'b0;
   logic                    RST = 1'b1;
   logic [3:0]              keypad_input = 4'd0;
   logic                    read_input = 1'b0;
   logic [3:0]              operator_input = 4'd0;
   logic                    equal_input = 1'b0;
   logic                    clear_input = 1'b0;
   logic signed [WIDTH-1:0] display_output;
   logic                    complete;
   logic                    busy;
   logic                    overflow;
   logic                    error;

   calc_core_n #(.WIDTH(WIDTH), .MAX_DIGITS(5)) dut (
      .clk(clk), .RST(RST), .keypad_input(keypad_input), .read_input(read_input),
      .operator_input(operator_input), .equal_input(equal_input), .clear_input(clear_input),
      .display_output(display_output), .complete(complete), .busy(busy),
      .overflow(overflow), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         a;
      logic [3:0] op;
      int         b;
      int         disp;
      bit         ovf;
      bit         err;
      int         lat;
      int         bsy;
   } vec_t;

   typedef struct {
      int disp;
      bit ovf;
      bit err;
      int lat;
      int bsy;
   } exp_t;

   vec_t vecs[10];
   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   fail_cnt  = 0;

   function automatic exp_t mk_exp(int disp, bit ovf, bit err, int lat, int bsy);
      exp_t e;
      e.disp = disp; e.ovf = ovf; e.err = err; e.lat = lat; e.bsy = bsy;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int disp_val();
      int v;
      v = display_output;
      return v;
   endfunction

   task automatic press_key(input logic [3:0] d);
      @(negedge clk) begin keypad_input = d; read_input = 1'b1; end
      @(negedge clk) read_input = 1'b0;
   endtask

   task automatic press_op(input logic [3:0] op);
      @(negedge clk) operator_input = op;
      @(negedge clk) operator_input = 4'd0;
   endtask

   task automatic do_clear();
      @(negedge clk) clear_input = 1'b1;
      @(negedge clk) clear_input = 1'b0;
   endtask

   task automatic enter_number(input int v);
      int d[12];
      int n;
      int x;
      n = 0;
      x = v;
      do begin
         d[n] = x % 10;
         x = x / 10;
         n++;
      end while (x > 0);
      for (int i = n - 1; i >= 0; i--) press_key(4'(d[i]));
   endtask

   // Pulse equal, then wait (bounded) for complete; latency counted from the edge that fires
   task automatic do_equal(input string tag, input exp_t e);
      exp_t ex;
      int   k;
      int   bcnt;
      bit   got;
      sb.push_back(e);
      @(negedge clk) equal_input = 1'b1;
      @(negedge clk) equal_input = 1'b0;
      k = 0; bcnt = 0; got = 1'b0;
      while (!got && k <= 60) begin
         if (complete) begin
            got = 1'b1;
         end else begin
            if (busy) bcnt++;
            k++;
            @(negedge clk);
         end
      end
      ex = sb.pop_front();
      if (!got) begin
         check({tag, "_timeout_complete"}, int'(complete), 1);
      end else begin
         check({tag, "_disp"}, disp_val(), ex.disp);
         check({tag, "_ovf"}, int'(overflow), int'(ex.ovf));
         check({tag, "_err"}, int'(error), int'(ex.err));
         check({tag, "_latency"}, k, ex.lat);
         check({tag, "_busy_cycles"}, bcnt, ex.bsy);
      end
   endtask

   initial begin
      vecs[0] = '{12,    OP_ADD, 34,    46,      1'b0, 1'b0, 2,  1};
      vecs[1] = '{7,     OP_SUB, 20,    -13,     1'b0, 1'b0, 2,  1};
      vecs[2] = '{300,   OP_MUL, 200,   MUL_OVF, 1'b1, 1'b0, 2,  1};
      vecs[3] = '{100,   OP_DIV, 7,     14,      1'b0, 1'b0, 19, 17};
      vecs[4] = '{5,     OP_DIV, 0,     0,       1'b0, 1'b1, 1,  1};
      vecs[5] = '{32767, OP_ADD, 1,     ADD_OVF, 1'b1, 1'b0, 2,  1};
      vecs[6] = '{32767, OP_MUL, 32767, SQ_OVF,  1'b1, 1'b0, 2,  1};
      vecs[7] = '{1,     OP_SUB, 32767, -32766,  1'b0, 1'b0, 2,  1};
      vecs[8] = '{99,    OP_DIV, 100,   0,       1'b0, 1'b0, 19, 17};
      vecs[9] = '{9,     OP_DIV, 9,     1,       1'b0, 1'b0, 19, 17};

      repeat (3) @(negedge clk);
      check("rst_disp", disp_val(), 0);
      check("rst_complete", int'(complete), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_err", int'(error), 0);
      RST = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         do_clear();
         check($sformatf("vec%0d_clear_disp", i), disp_val(), 0);
         check($sformatf("vec%0d_clear_complete", i), int'(complete), 0);
         enter_number(vecs[i].a);
         press_op(vecs[i].op);
         enter_number(vecs[i].b);
         do_equal($sformatf("vec%0d", i),
                  mk_exp(vecs[i].disp, vecs[i].ovf, vecs[i].err, vecs[i].lat, vecs[i].bsy));
      end

      // Chaining: -13 then mul 3
      do_clear();
      enter_number(7); press_op(OP_SUB); enter_number(20);
      do_equal("chain_first", mk_exp(-13, 1'b0, 1'b0, 2, 1));
      press_op(OP_MUL);
      check("chain_b_disp", disp_val(), 0);
      check("chain_b_complete", int'(complete), 0);
      press_key(4'd3);
      check("chain_b_digit", disp_val(), 3);
      do_equal("chain_mul", mk_exp(-39, 1'b0, 1'b0, 2, 1));

      // Negative dividend truncates toward zero
      do_clear();
      enter_number(0); press_op(OP_SUB); enter_number(100);
      do_equal("neg_first", mk_exp(-100, 1'b0, 1'b0, 2, 1));
      press_op(OP_DIV); press_key(4'd7);
      do_equal("neg_div", mk_exp(-14, 1'b0, 1'b0, 19, 17));

      // Divide by zero, then a digit press starts fresh and clears error
      do_clear();
      enter_number(5); press_op(OP_DIV); enter_number(0);
      do_equal("div0", mk_exp(0, 1'b0, 1'b1, 1, 1));
      press_key(4'd4);
      check("div0_digit_err", int'(error), 0);
      check("div0_digit_disp", disp_val(), 4);
      check("div0_digit_complete", int'(complete), 0);
      do_equal("eq_in_a", mk_exp(4, 1'b0, 1'b0, 0, 0));

      // Entry limits: range, non-BCD key, digit count
      do_clear();
      enter_number(99999);
      check("range_9999", disp_val(), 9999);
      do_clear();
      press_key(4'd1); press_key(4'd12);
      check("bad_key", disp_val(), 1);
      do_clear();
      repeat (5) press_key(4'd0);
      press_key(4'd7);
      check("max_digits", disp_val(), 0);
      press_op(OP_ADD); press_key(4'd7);
      check("b_after_limit", disp_val(), 7);
      do_equal("limit_add", mk_exp(7, 1'b0, 1'b0, 2, 1));

      // Reset in the middle of a divide
      do_clear();
      enter_number(100); press_op(OP_DIV); enter_number(7);
      @(negedge clk) equal_input = 1'b1;
      @(negedge clk) equal_input = 1'b0;
      repeat (5) @(negedge clk);
      check("middiv_busy", int'(busy), 1);
      RST = 1'b1;
      #1;
      check("middiv_rst_disp", disp_val(), 0);
      check("middiv_rst_busy", int'(busy), 0);
      check("middiv_rst_complete", int'(complete), 0);
      check("middiv_rst_ovf", int'(overflow), 0);
      check("middiv_rst_err", int'(error), 0);
      @(negedge clk) RST = 1'b0;
      repeat (25) @(negedge clk);
      check("middiv_no_result", int'(complete), 0);
      press_key(4'd5);
      do_equal("after_rst", mk_exp(5, 1'b0, 1'b0, 0, 0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/calc_core_n.md
Name: calc_core_n

Overview:
- Parametrised successor to the 16-bit keypad calculator controller.
- Accumulates decimal keypad digits into two signed WIDTH-bit operands and applies a one-hot operator: add, sub, mul, or multi-cycle signed divide.
- Drives a display bus plus status flags: complete, busy, overflow, error.
- Supports result chaining, so a new operator can be applied directly to the last result.

Parameters:
- WIDTH, 16: operand/result width, two's complement; legal 8..32.
- MAX_DIGITS, 5: maximum decimal digits accepted per operand.

Ports:
- clk  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- keypad_input  in  4  BCD digit; sampled on read_input rising edge
- read_input  in  1  digit strobe; level, rising edge detected internally
- operator_input  in  4  one-hot: 0001 add, 0010 sub, 0100 mul, 1000 div
- equal_input  in  1  evaluate strobe; rising edge detected
- clear_input  in  1  synchronous clear; level
- display_output  out  WIDTH  signed; shows operand being entered, or the result
- complete  out  1  high while a valid result is displayed
- busy  out  1  high during EXEC/DIV_RUN
- overflow  out  1  last result exceeded signed range
- error  out  1  divide by zero

Behaviour:
- Reset (RST high, async): state ENTER_A; operands, operator and digit count cleared; all outputs 0; edge-detect registers cleared.
- Strobe detection:
  - read_input, equal_input and operator_input (zero to nonzero) are registered once.
  - An action fires on the first clk where the registered value is 0 and the current value is 1.
  - Each strobe must be high for at least 1 clk.
- Priority in the same cycle: clear > equal > operator > digit.
- clear_input: from any state, returns to ENTER_A next cycle; same values as reset.
- Digit entry (ENTER_A / ENTER_B), MSD first:
  - acc <= acc*10 + digit.
  - Digit is ignored if keypad_input > 9, if count == MAX_DIGITS, or if the result would exceed 2^(WIDTH-1)-1.
  - display_output = acc.
- Operator edge:
  - In ENTER_A: latch op and go to ENTER_B with B = 0.
  - In ENTER_B: replaces op; B is kept.
  - In DONE: A <= result, latch op, go to ENTER_B (chaining).
  - Non-one-hot codes are ignored.
- Digit edge in DONE: starts a fresh A with that digit; flags cleared.
- Equal edge:
  - In ENTER_B: go to EXEC.
  - In ENTER_A: result = A; go to DONE.
  - Ignored in DONE.
- EXEC (1 cycle): add/sub/mul computed at 2*WIDTH precision, then range-checked. Div goes to DIV_RUN.
- DIV_RUN:
  - Restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
  - Then one sign-fixup cycle; quotient truncates toward zero.
- Divide-by-zero detected in EXEC: error = 1, result = 0, go to DONE.
- MIN / -1 sets overflow.
- Latency, counted from the clk on which the equal edge fires:
  - complete rises 2 cycles later for add/sub/mul.
  - complete rises WIDTH+3 cycles later for div.
- busy is high in EXEC and DIV_RUN only. All inputs except clear and RST are ignored while busy.
- DONE: display_output = result, complete = 1; held until the next digit, operator or clear.
- overflow and error are held until the next operand entry starts or a clear.
- Reset mid-divide: aborts immediately; no partial result is visible.

Optional Feature:
- Macro CALC_SATURATE_EN.
- Defined: an out-of-range result clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1); overflow = 1.
- Undefined: the result wraps modulo 2^WIDTH (low WIDTH bits kept); overflow = 1 still.

Test Plan:
- WIDTH=16: digits 1,2 then 0001, digits 3,4, equal -> display 46, complete 2 cycles after the equal edge, overflow 0.
- 7, sub, 20, equal -> -13. Then operator mul, digit 3, equal (chaining) -> -39.
- 300, mul, 200, equal:
  - with CALC_SATURATE_EN -> 32767, overflow 1;
  - without -> 60000 mod 65536 read as signed = -5536, overflow 1.
- 100, div, 7, equal -> busy for 17 cycles, then 14, complete at the 19th cycle.
- 5, div, 0, equal -> error 1, display 0. Then a digit press clears error.
- Digit entry 9,9,9,9,9 -> 9999 (5th digit rejected by range).
- Reset asserted mid-DIV_RUN -> all outputs 0 immediately, state ENTER_A.
